// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : comp_pkg
// Description : Shared types and defaults for the magnitude comparator and
//               the frame min/max tracker built on top of it.
//               - cmp_res_t   : {lt, eq, gt} comparator result
//               - trk_state_t : IDLE / ACC / DONE tracker states
//               - CMP_W_DEFAULT, IDX_W_DEFAULT : default widths
// Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

  localparam int CMP_W_DEFAULT = 16;
  localparam int IDX_W_DEFAULT = 8;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } trk_state_t;

endpackage : comp_pkg
`default_nettype wire

// File: rtl/comp_mag.sv
`default_nettype none
// ============================================================================
// Module      : comp_mag
// Description : Combinational W-bit unsigned magnitude comparator. Operands
//               are split into 4-bit groups; the most significant group that
//               differs decides the result.
// Ports       : a_i   [W-1:0]  left operand
//               b_i   [W-1:0]  right operand
//               res_o cmp_res_t {lt, eq, gt} of a_i versus b_i
// Revision    : 1.0 - initial release
// ============================================================================
module comp_mag
  import comp_pkg::*;
#(
  parameter int W = CMP_W_DEFAULT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output cmp_res_t     res_o
);

  // Round the operand up to a whole number of 4-bit groups.
  localparam int C_NG = (W + 3) / 4;
  localparam int C_WP = C_NG * 4;

  logic [C_WP-1:0] w_a;
  logic [C_WP-1:0] w_b;
  logic [C_NG-1:0] w_glt;
  logic [C_NG-1:0] w_ggt;
  cmp_res_t        w_res;

  assign w_a = C_WP'(a_i);
  assign w_b = C_WP'(b_i);

  for (genvar g = 0; g < C_NG; g++) begin : g_grp
    assign w_glt[g] = (w_a[g*4 +: 4] < w_b[g*4 +: 4]);
    assign w_ggt[g] = (w_a[g*4 +: 4] > w_b[g*4 +: 4]);
  end

  // Scanning from the LSB group upward, later (more significant) unequal
  // groups overwrite earlier ones, which gives MSB-first priority.
  always_comb begin
    w_res = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
    for (int g = 0; g < C_NG; g++) begin
      if (w_glt[g] || w_ggt[g]) begin
        w_res.lt = w_glt[g];
        w_res.gt = w_ggt[g];
        w_res.eq = 1'b0;
      end
    end
  end

  assign res_o = w_res;

endmodule : comp_mag
`default_nettype wire

// File: rtl/comp_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : comp_frame_tracker
// Description : Streaming stage that tracks the running maximum and minimum
//               of each input frame (first-occurrence indices) and emits one
//               result beat per frame with max, min, both indices and a
//               saturating sample count.
// Config      : COMP_FRAME_TRACKER_SIGNED_EN - when defined, samples are
//               compared as two's complement; otherwise unsigned.
// Ports       : clk, rst               clock, synchronous active-high reset
//               in_valid/in_ready      sample handshake
//               in_data [W-1:0]        sample
//               in_last                final sample of frame
//               out_valid/out_ready    result handshake
//               out_max/out_min        frame extremes
//               out_max_idx/out_min_idx first-occurrence indices
//               out_count              samples in frame (saturating)
//               out_ovf                frame longer than 2^IDX_W-1 samples
// Revision    : 1.0 - initial release
// ============================================================================
module comp_frame_tracker
  import comp_pkg::*;
#(
  parameter int W     = CMP_W_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_max,
  output logic [W-1:0]     out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [IDX_W-1:0] C_CNT_MAX = '1;

  // Flipping the MSB of both operands maps two's complement order onto
  // unsigned order, so one unsigned comparator serves both modes.
`ifdef COMP_FRAME_TRACKER_SIGNED_EN
  localparam logic [W-1:0] C_MSB_FLIP = {1'b1, {(W-1){1'b0}}};
`else
  localparam logic [W-1:0] C_MSB_FLIP = '0;
`endif

  trk_state_t       state_q, state_d;
  logic [W-1:0]     max_q, max_d;
  logic [W-1:0]     min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0] w_smp_cmp;
  logic [W-1:0] w_max_cmp;
  logic [W-1:0] w_min_cmp;
  cmp_res_t     w_vs_max;
  cmp_res_t     w_vs_min;

  assign w_smp_cmp = in_data ^ C_MSB_FLIP;
  assign w_max_cmp = max_q   ^ C_MSB_FLIP;
  assign w_min_cmp = min_q   ^ C_MSB_FLIP;

  comp_mag #(.W(W)) u_cmp_max (
    .a_i   (w_smp_cmp),
    .b_i   (w_max_cmp),
    .res_o (w_vs_max)
  );

  comp_mag #(.W(W)) u_cmp_min (
    .a_i   (w_smp_cmp),
    .b_i   (w_min_cmp),
    .res_o (w_vs_min)
  );

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          max_d     = in_data;
          min_d     = in_data;
          max_idx_d = '0;
          min_idx_d = '0;
          count_d   = IDX_W'(1);
          ovf_d     = 1'b0;
          state_d   = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          // Strict comparisons only: ties keep the first occurrence. The
          // eq term is redundant for a well-formed result but keeps the
          // update gated off on any equal compare.
          if (w_vs_max.gt && !w_vs_max.eq) begin
            max_d     = in_data;
            max_idx_d = count_q;
          end
          if (w_vs_min.lt && !w_vs_min.eq) begin
            min_d     = in_data;
            min_idx_d = count_q;
          end
          // Once saturated the count (and hence any later index) sticks at
          // the maximum and the overflow flag latches for this frame.
          if (count_q == C_CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign in_ready    = (state_q != DONE);
  assign out_valid   = (state_q == DONE);
  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
  assign out_count   = count_q;
  assign out_ovf     = ovf_q;

endmodule : comp_frame_tracker
`default_nettype wire

// File: tb/tb_comp_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_frame_tracker
// Description : Self-checking bench for comp_frame_tracker. A table of frames
//               with their expected results is driven through the main DUT;
//               expected results go to a scoreboard queue and are compared
//               when the DUT delivers a result. Hand-written sequences cover
//               reset, back-pressure, mid-frame reset and count saturation
//               (on a second instance with IDX_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_frame_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [15:0] in_data, out_max, out_min;
  logic [7:0]  out_max_idx, out_min_idx, out_count;

  logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_ovf4;
  logic [15:0] in_data4, out_max4, out_min4;
  logic [3:0]  out_max_idx4, out_min_idx4, out_count4;

  always #5 clk = ~clk;

  comp_frame_tracker #(.W(16), .IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min),
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  comp_frame_tracker #(.W(16), .IDX_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_max(out_max4), .out_min(out_min4),
    .out_max_idx(out_max_idx4), .out_min_idx(out_min_idx4),
    .out_count(out_count4), .out_ovf(out_ovf4)
  );

  typedef struct packed {
    logic [15:0] mx;
    logic [15:0] mn;
    logic [7:0]  mxi;
    logic [7:0]  mni;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [2:0]       n;
    logic [4:0][15:0] s;
    res_t             exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t mon_e, mon_a;

  function automatic vec_t mk(input int n, input logic [15:0] s0, s1, s2, s3, s4,
                              input logic [15:0] mx, mn, input int mxi, mni, cnt);
    vec_t v;
    v.n       = 3'(n);
    v.s       = {s4, s3, s2, s1, s0};
    v.exp.mx  = mx;
    v.exp.mn  = mn;
    v.exp.mxi = 8'(mxi);
    v.exp.mni = 8'(mni);
    v.exp.cnt = 8'(cnt);
    v.exp.ovf = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare on every delivered result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      mon_a = {out_max, out_min, out_max_idx, out_min_idx, out_count, out_ovf};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%0h expected=none", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL sb_result actual=%0h expected=%0h", mon_a, mon_e);
        end
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low expected=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    exp_q.push_back(v.exp);
    for (int i = 0; i < int'(v.n); i++) begin
      send_beat(v.s[i], (i == int'(v.n) - 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = mk(5, 16'd5, 16'd9, 16'd2, 16'd9, 16'd2, 16'd9, 16'd2, 1, 2, 5);
    vecs[1] = mk(1, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h1234, 0, 0, 1);
    vecs[2] = mk(3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd0, 16'd3, 16'd3, 0, 0, 3);
    vecs[3] = mk(5, 16'd10, 16'd8, 16'd6, 16'd4, 16'd1, 16'd10, 16'd1, 0, 4, 5);
`ifdef COMP_FRAME_TRACKER_SIGNED_EN
    vecs[4] = mk(4, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1, 0, 4);
    vecs[5] = mk(2, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h8000, 1, 0, 2);
`else
    vecs[4] = mk(4, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0, 0, 1, 4);
    vecs[5] = mk(2, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0001, 0, 1, 2);
`endif
    vecs[6] = mk(2, 16'd7, 16'd3, 16'd0, 16'd0, 16'd0, 16'd7, 16'd3, 0, 1, 2);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_last4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({out_max, out_min, out_max_idx, out_min_idx, out_count, out_ovf}), 64'd0);

    // Table: each frame, result must be valid the cycle after the last beat
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i]);
      chk($sformatf("latency_v%0d", i), 64'(out_valid), 64'd1);
      drain();
    end

    // Back-pressure: result held for 10 cycles while a new beat waits
    out_ready = 1'b0;
    send_frame(vecs[0]);
    in_valid = 1'b1; in_data = 16'h0055; in_last = 1'b1;
    exp_q.push_back('{mx: 16'h55, mn: 16'h55, mxi: 8'd0, mni: 8'd0, cnt: 8'd1, ovf: 1'b0});
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_in_ready",  64'(in_ready),  64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({out_max, out_min, out_max_idx, out_min_idx, out_count, out_ovf}),
          64'(vecs[0].exp));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready",  64'(in_ready),  64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("next_frame_accept", 64'(out_valid), 64'd1);
    drain();

    // Reset after 3 beats of a frame discards it
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    send_beat(16'd50,  1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_count",     64'(out_count), 64'd0);
    send_frame(vecs[6]);
    drain();

    // Count saturation on the IDX_W=4 instance: 20 ascending samples
    in_valid4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data4 = 16'h0100 + 16'(i);
      in_last4 = (i == 19);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0; in_last4 = 1'b0;
    chk("sat_valid",   64'(out_valid4),   64'd1);
    chk("sat_max",     64'(out_max4),     64'h0113);
    chk("sat_min",     64'(out_min4),     64'h0100);
    chk("sat_max_idx", 64'(out_max_idx4), 64'd15);
    chk("sat_min_idx", 64'(out_min_idx4), 64'd0);
    chk("sat_count",   64'(out_count4),   64'd15);
    chk("sat_ovf",     64'(out_ovf4),     64'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b1; in_data4 = 16'd7; in_last4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_last4 = 1'b0;
    chk("sat_next_valid", 64'(out_valid4), 64'd1);
    chk("sat_next_ovf",   64'(out_ovf4),   64'd0);
    chk("sat_next_count", 64'(out_count4), 64'd1);

    repeat (3) @(posedge clk);
    chk("sb_final_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_comp_frame_tracker
`default_nettype wire
